fifo_wr_frontend: RTL and testbench

Write-domain front end of the asynchronous FIFO. It accepts producer data over a valid/ready handshake and drives the dual-port memory write port. It maintains the binary and Gray write pointers and synchronizes the read-domain Gray pointer into wr_clk with two flops. From these it produces full, almost-full, fill level and a stall counter for the write-side control logic.

---
 rtl/fifo_wr_frontend.sv | 121 ++++++++++++
 tb/tb_fifo_wr_frontend.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_frontend.sv
// fifo_wr_frontend
// Write-domain front end of an asynchronous FIFO. It accepts producer data
// over a valid/ready handshake and drives the write port of the dual-port
// memory. It keeps the binary and Gray write pointers. The read-domain Gray
// pointer is brought into wr_clk through a two-flop synchronizer. From these
// pointers the block derives full, almost-full, the fill level and a
// saturating stall counter.
//
// Ports
//   wr_clk, wr_rst   write clock; asynchronous active-high reset
//   in_valid/ready   producer handshake (in_ready = !fifo_full)
//   in_data          producer data, DW bits
//   rd_ptr_gray      Gray read pointer from the rd_clk domain, AW+1 bits
//   mem_we/waddr/    memory write port, combinational from the handshake
//   mem_wdata
//   wr_ptr_gray      registered Gray write pointer sent to the read domain
//   fifo_full        FIFO holds 2^AW entries
//   almost_full      wr_level >= AF_THRESH
//   wr_level         occupancy seen from the write side (pessimistic)
//   wr_stall_cnt     cycles with in_valid while full, saturating at 255
module fifo_wr_frontend #(
  parameter int DW        = 8,
  parameter int AW        = 4,
  parameter int AF_THRESH = 12
) (
  input  logic          wr_clk,
  input  logic          wr_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW:0]   rd_ptr_gray,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW:0]   wr_ptr_gray,
  output logic          fifo_full,
  output logic          almost_full,
  output logic [AW:0]   wr_level,
  output logic [7:0]    wr_stall_cnt
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AF_LVL  = (AW+1)'(AF_THRESH);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic [AW:0] rsync1_q, rsync1_d;
  logic [AW:0] rsync2_q, rsync2_d;
  logic [7:0]  stall_q, stall_d;

  logic [AW:0] rbin;
  logic [AW:0] wbin_inc;
  logic        full;
  logic        acc;

  // Read pointer back to binary: each bit is the XOR of itself and every
  // more significant Gray bit.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin[i] = ^(rsync2_q >> i);
    end
  end

  // Full when the write pointer has lapped the read pointer by one whole
  // depth. In Gray code this means the top two bits are inverted and the
  // rest are equal. Only registered values are used, so in_ready never
  // depends on in_valid.
  always_comb begin
    full        = (wgray_q == {~rsync2_q[AW:AW-1], rsync2_q[AW-2:0]});
    acc         = in_valid & ~full;
    wr_level    = wbin_q - rbin;
    almost_full = (wr_level >= AF_LVL);
  end

  // Next-state logic. The Gray pointer is computed from the incremented
  // binary pointer and then registered. The value sent across domains comes
  // straight from a flop, so only one bit changes per write.
  always_comb begin
    wbin_inc = wbin_q + PTR_ONE;
    wbin_d   = wbin_q;
    wgray_d  = wgray_q;
    rsync1_d = rd_ptr_gray;
    rsync2_d = rsync1_q;
    stall_d  = stall_q;
    if (acc) begin
      wbin_d  = wbin_inc;
      wgray_d = wbin_inc ^ (wbin_inc >> 1);
    end
    if (in_valid && full && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // State registers. The asynchronous reset clears the pointers, the
  // synchronizer and the counter at once.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
      stall_q  <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rsync1_q <= rsync1_d;
      rsync2_q <= rsync2_d;
      stall_q  <= stall_d;
    end
  end

  assign in_ready     = ~full;
  assign fifo_full    = full;
  assign mem_we       = acc;
  assign mem_waddr    = wbin_q[AW-1:0];
  assign mem_wdata    = in_data;
  assign wr_ptr_gray  = wgray_q;
  assign wr_stall_cnt = stall_q;

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed testbench for fifo_wr_frontend with AW=4, DW=8, AF_THRESH=12.
// A small reference model tracks the write pointer in binary. It also keeps
// the binary read pointer delayed by two edges and the stall count. Expected
// outputs come from this model and from hand-computed constants.
module tb_fifo_wr_frontend;

  logic       wr_clk;
  logic       wr_rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] rd_ptr_gray;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [4:0] wr_ptr_gray;
  logic       fifo_full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic [7:0] wr_stall_cnt;

  int n_compared;
  int n_mismatched;

  // Reference model state
  logic [4:0] wbin_m;
  logic [4:0] rb1_m;
  logic [4:0] rb2_m;
  int         stall_m;

  fifo_wr_frontend #(.DW(8), .AW(4), .AF_THRESH(12)) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .rd_ptr_gray  (rd_ptr_gray),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .wr_ptr_gray  (wr_ptr_gray),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .wr_stall_cnt (wr_stall_cnt)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  function automatic logic [4:0] toGray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    wbin_m  = '0;
    rb1_m   = '0;
    rb2_m   = '0;
    stall_m = 0;
  endtask

  // Called at a falling edge. It drives the inputs for one cycle and checks
  // the combinational port before the rising edge. After the edge it updates
  // the model and checks the registered outputs, then returns at the next
  // falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic [4:0] rp);
    logic [4:0] lvl;
    logic       full_e;
    logic       acc_e;
    in_valid    = v;
    in_data     = d;
    rd_ptr_gray = toGray(rp);
    #1;
    lvl    = wbin_m - rb2_m;
    full_e = (lvl == 5'd16);
    acc_e  = v & ~full_e;
    checkOutput("in_ready_pre", {31'd0, in_ready}, {31'd0, ~full_e});
    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, acc_e});
    if (acc_e) begin
      checkOutput("mem_waddr", {28'd0, mem_waddr}, {28'd0, wbin_m[3:0]});
      checkOutput("mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
    end
    @(posedge wr_clk);
    if (acc_e) wbin_m = wbin_m + 5'd1;
    rb2_m = rb1_m;
    rb1_m = rp;
    if (v && full_e && stall_m < 255) stall_m++;
    #1;
    lvl = wbin_m - rb2_m;
    checkOutput("wr_level", {27'd0, wr_level}, {27'd0, lvl});
    checkOutput("wr_ptr_gray", {27'd0, wr_ptr_gray}, {27'd0, toGray(wbin_m)});
    checkOutput("fifo_full", {31'd0, fifo_full}, {31'd0, (lvl == 5'd16)});
    checkOutput("almost_full", {31'd0, almost_full}, {31'd0, (lvl >= 5'd12)});
    checkOutput("wr_stall_cnt", {24'd0, wr_stall_cnt}, stall_m);
    @(negedge wr_clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_fifo_full"}, {31'd0, fifo_full}, 32'd0);
    checkOutput({tag, "_almost_full"}, {31'd0, almost_full}, 32'd0);
    checkOutput({tag, "_wr_level"}, {27'd0, wr_level}, 32'd0);
    checkOutput({tag, "_wr_ptr_gray"}, {27'd0, wr_ptr_gray}, 32'd0);
    checkOutput({tag, "_wr_stall_cnt"}, {24'd0, wr_stall_cnt}, 32'd0);
    checkOutput({tag, "_mem_waddr"}, {28'd0, mem_waddr}, 32'd0);
  endtask

  initial begin
    logic [4:0] rp;
    n_compared   = 0;
    n_mismatched = 0;
    modelReset();
    wr_rst      = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    rd_ptr_gray = 5'b00000;

    // Reset state, then after reset release
    #12;
    checkResetOutputs("rst");
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge wr_clk);
    wr_rst = 1'b0;
    @(posedge wr_clk);
    #1;
    checkResetOutputs("post_rst");
    @(negedge wr_clk);

    // Fill with 16 writes while the read pointer stays at 0
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 5'd0);
    end
    checkOutput("fill_full", {31'd0, fifo_full}, 32'd1);
    checkOutput("fill_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fill_level", {27'd0, wr_level}, 32'd16);
    checkOutput("fill_gray", {27'd0, wr_ptr_gray}, 32'b11000);

    // Stall while full: 3 cycles, then up to 300 in total (saturates)
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hAA, 5'd0);
    checkOutput("stall3_cnt", {24'd0, wr_stall_cnt}, 32'd3);
    checkOutput("stall3_gray", {27'd0, wr_ptr_gray}, 32'b11000);
    for (int i = 3; i < 300; i++) applyStimulus(1'b1, 8'hAA, 5'd0);
    checkOutput("stall300_cnt", {24'd0, wr_stall_cnt}, 32'd255);

    // Read release: read pointer 1 takes two edges to clear full
    in_valid    = 1'b0;
    rd_ptr_gray = 5'b00001;
    @(posedge wr_clk);
    #1;
    checkOutput("release_edge1_full", {31'd0, fifo_full}, 32'd1);
    @(posedge wr_clk);
    #1;
    checkOutput("release_edge2_full", {31'd0, fifo_full}, 32'd0);
    checkOutput("release_level", {27'd0, wr_level}, 32'd15);
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    rb1_m = 5'd1;
    rb2_m = 5'd1;
    @(negedge wr_clk);

    // Wrap-around: bring the level to 4, then write and read every cycle
    applyStimulus(1'b0, 8'h00, 5'd12);
    applyStimulus(1'b0, 8'h00, 5'd12);
    checkOutput("wrap_start_level", {27'd0, wr_level}, 32'd4);
    rp = 5'd12;
    for (int k = 0; k < 16; k++) begin
      rp = rp + 5'd1;
      if (wbin_m == 5'd31) begin
        checkOutput("wrap_gray_31", {27'd0, wr_ptr_gray}, 32'b10000);
        applyStimulus(1'b1, 8'(8'h40 + k), rp);
        checkOutput("wrap_gray_0", {27'd0, wr_ptr_gray}, 32'b00000);
      end else begin
        applyStimulus(1'b1, 8'(8'h40 + k), rp);
      end
    end
    applyStimulus(1'b0, 8'h00, 5'd16);
    applyStimulus(1'b0, 8'h00, 5'd16);
    checkOutput("wrap_full", {31'd0, fifo_full}, 32'd1);
    checkOutput("wrap_level", {27'd0, wr_level}, 32'd16);

    // Reset mid-stream: fill to level 9, then assert reset in mid-cycle
    wr_rst = 1'b1;
    #1;
    wr_rst      = 1'b0;
    rd_ptr_gray = 5'b00000;
    modelReset();
    @(negedge wr_clk);
    applyStimulus(1'b0, 8'h00, 5'd0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'h80 + i), 5'd0);
    checkOutput("mid_level9", {27'd0, wr_level}, 32'd9);
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(posedge wr_clk);
    #1;
    checkOutput("mid_level10", {27'd0, wr_level}, 32'd10);
    #2;
    wr_rst = 1'b1;
    #1;
    checkResetOutputs("mid_rst");
    @(negedge wr_clk);
    wr_rst = 1'b0;
    modelReset();
    applyStimulus(1'b1, 8'h5A, 5'd0);
    checkOutput("post_mid_gray", {27'd0, wr_ptr_gray}, 32'b00001);
    checkOutput("post_mid_level", {27'd0, wr_level}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
